// File: rtl/pio_arb_pkg.sv
// Shared types for the two-manager AXI4-Lite arbiter in front of the PIO control port.
package pio_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_0    = 2'b01;
  localparam logic [1:0] GRANT_1    = 2'b10;

endpackage

// File: rtl/pio_arb2.sv
// One 2-way arbiter: registered one-hot grant held from request until release.
// Tie-break is round-robin when PIO_ARB_RR_EN is defined, otherwise manager 0 wins.
module pio_arb2
  import pio_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       rel,
  output logic [1:0] grant,
  output arb_state_t state
);

  arb_state_t state_nxt;
  logic [1:0] grant_nxt;
  logic [1:0] pick;

`ifdef PIO_ARB_RR_EN
  // last_q holds the previous owner; on a tie the other manager wins.
  logic last_q;
  logic last_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= 1'b0;
    else          last_q <= last_nxt;
  end

  always_comb begin
    last_nxt = last_q;
    if (state == BUSY && rel) last_nxt = grant[1];
    if (req == 2'b11)  pick = last_q ? GRANT_0 : GRANT_1;
    else if (req[0])   pick = GRANT_0;
    else if (req[1])   pick = GRANT_1;
    else               pick = GRANT_NONE;
  end
`else
  always_comb begin
    if (req[0])      pick = GRANT_0;
    else if (req[1]) pick = GRANT_1;
    else             pick = GRANT_NONE;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= GRANT_NONE;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: if (|req) begin
        state_nxt = BUSY;
        grant_nxt = pick;
      end
      BUSY: if (rel) begin
        state_nxt = IDLE;
        grant_nxt = GRANT_NONE;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = GRANT_NONE;
      end
    endcase
  end

endmodule

// File: rtl/pio_axil_arbiter.sv
// Shares the PIO t_ctrl AXI4-Lite port between two managers; write and read paths arbitrate independently.
// Build option: define PIO_ARB_RR_EN for round-robin tie-breaking (default is fixed priority, manager 0).
module pio_axil_arbiter
  import pio_arb_pkg::*;
#(
  parameter int addrWidth        = 32,
  parameter int dataWidth        = 32,
  parameter int writeStrobeWidth = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        t0_ctrl_awvalid,
  input  logic [addrWidth-1:0]        t0_ctrl_awaddr,
  input  logic [2:0]                  t0_ctrl_awprot,
  output logic                        t0_ctrl_awready,
  input  logic                        t0_ctrl_wvalid,
  input  logic [dataWidth-1:0]        t0_ctrl_wdata,
  input  logic [writeStrobeWidth-1:0] t0_ctrl_wstrb,
  output logic                        t0_ctrl_wready,
  output logic                        t0_ctrl_bvalid,
  output logic [1:0]                  t0_ctrl_bresp,
  input  logic                        t0_ctrl_bready,
  input  logic                        t0_ctrl_arvalid,
  input  logic [addrWidth-1:0]        t0_ctrl_araddr,
  input  logic [2:0]                  t0_ctrl_arprot,
  output logic                        t0_ctrl_arready,
  output logic                        t0_ctrl_rvalid,
  output logic [dataWidth-1:0]        t0_ctrl_rdata,
  output logic [1:0]                  t0_ctrl_rresp,
  input  logic                        t0_ctrl_rready,
  input  logic                        t1_ctrl_awvalid,
  input  logic [addrWidth-1:0]        t1_ctrl_awaddr,
  input  logic [2:0]                  t1_ctrl_awprot,
  output logic                        t1_ctrl_awready,
  input  logic                        t1_ctrl_wvalid,
  input  logic [dataWidth-1:0]        t1_ctrl_wdata,
  input  logic [writeStrobeWidth-1:0] t1_ctrl_wstrb,
  output logic                        t1_ctrl_wready,
  output logic                        t1_ctrl_bvalid,
  output logic [1:0]                  t1_ctrl_bresp,
  input  logic                        t1_ctrl_bready,
  input  logic                        t1_ctrl_arvalid,
  input  logic [addrWidth-1:0]        t1_ctrl_araddr,
  input  logic [2:0]                  t1_ctrl_arprot,
  output logic                        t1_ctrl_arready,
  output logic                        t1_ctrl_rvalid,
  output logic [dataWidth-1:0]        t1_ctrl_rdata,
  output logic [1:0]                  t1_ctrl_rresp,
  input  logic                        t1_ctrl_rready,
  output logic                        i_ctrl_awvalid,
  output logic [addrWidth-1:0]        i_ctrl_awaddr,
  output logic [2:0]                  i_ctrl_awprot,
  input  logic                        i_ctrl_awready,
  output logic                        i_ctrl_wvalid,
  output logic [dataWidth-1:0]        i_ctrl_wdata,
  output logic [writeStrobeWidth-1:0] i_ctrl_wstrb,
  input  logic                        i_ctrl_wready,
  input  logic                        i_ctrl_bvalid,
  input  logic [1:0]                  i_ctrl_bresp,
  output logic                        i_ctrl_bready,
  output logic                        i_ctrl_arvalid,
  output logic [addrWidth-1:0]        i_ctrl_araddr,
  output logic [2:0]                  i_ctrl_arprot,
  input  logic                        i_ctrl_arready,
  input  logic                        i_ctrl_rvalid,
  input  logic [dataWidth-1:0]        i_ctrl_rdata,
  input  logic [1:0]                  i_ctrl_rresp,
  output logic                        i_ctrl_rready,
  output logic [1:0]                  wgrant,
  output logic [1:0]                  rgrant,
  output arb_state_t                  wr_state,
  output arb_state_t                  rd_state
);

  // Every channel is valid/ready: a beat moves on the rising edge where both are high,
  // and the source holds valid and payload steady until that edge.
  logic wsel, wbusy, wrel, aw_done, w_done;
  logic rsel, rbusy, rrel, ar_done;

  assign wsel  = wgrant[1];
  assign wbusy = (wr_state == BUSY);
  assign rsel  = rgrant[1];
  assign rbusy = (rd_state == BUSY);

  // Write path; a channel's valid is masked once its beat has been accepted.
  assign i_ctrl_awvalid = wbusy & ~aw_done & (wsel ? t1_ctrl_awvalid : t0_ctrl_awvalid);
  assign i_ctrl_awaddr  = wsel ? t1_ctrl_awaddr : t0_ctrl_awaddr;
  assign i_ctrl_awprot  = wsel ? t1_ctrl_awprot : t0_ctrl_awprot;
  assign i_ctrl_wvalid  = wbusy & ~w_done & (wsel ? t1_ctrl_wvalid : t0_ctrl_wvalid);
  assign i_ctrl_wdata   = wsel ? t1_ctrl_wdata : t0_ctrl_wdata;
  assign i_ctrl_wstrb   = wsel ? t1_ctrl_wstrb : t0_ctrl_wstrb;
  assign i_ctrl_bready  = wbusy & (wsel ? t1_ctrl_bready : t0_ctrl_bready);

  assign t0_ctrl_awready = wgrant[0] & ~aw_done & i_ctrl_awready;
  assign t1_ctrl_awready = wgrant[1] & ~aw_done & i_ctrl_awready;
  assign t0_ctrl_wready  = wgrant[0] & ~w_done & i_ctrl_wready;
  assign t1_ctrl_wready  = wgrant[1] & ~w_done & i_ctrl_wready;
  assign t0_ctrl_bvalid  = wgrant[0] & i_ctrl_bvalid;
  assign t1_ctrl_bvalid  = wgrant[1] & i_ctrl_bvalid;
  assign t0_ctrl_bresp   = wgrant[0] ? i_ctrl_bresp : 2'b00;
  assign t1_ctrl_bresp   = wgrant[1] ? i_ctrl_bresp : 2'b00;

  assign wrel = wbusy & aw_done & w_done & i_ctrl_bvalid & i_ctrl_bready;

  // Read path.
  assign i_ctrl_arvalid = rbusy & ~ar_done & (rsel ? t1_ctrl_arvalid : t0_ctrl_arvalid);
  assign i_ctrl_araddr  = rsel ? t1_ctrl_araddr : t0_ctrl_araddr;
  assign i_ctrl_arprot  = rsel ? t1_ctrl_arprot : t0_ctrl_arprot;
  assign i_ctrl_rready  = rbusy & (rsel ? t1_ctrl_rready : t0_ctrl_rready);

  assign t0_ctrl_arready = rgrant[0] & ~ar_done & i_ctrl_arready;
  assign t1_ctrl_arready = rgrant[1] & ~ar_done & i_ctrl_arready;
  assign t0_ctrl_rvalid  = rgrant[0] & i_ctrl_rvalid;
  assign t1_ctrl_rvalid  = rgrant[1] & i_ctrl_rvalid;
  assign t0_ctrl_rdata   = i_ctrl_rdata;
  assign t1_ctrl_rdata   = i_ctrl_rdata;
  assign t0_ctrl_rresp   = rgrant[0] ? i_ctrl_rresp : 2'b00;
  assign t1_ctrl_rresp   = rgrant[1] ? i_ctrl_rresp : 2'b00;

  assign rrel = rbusy & ar_done & i_ctrl_rvalid & i_ctrl_rready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (wrel) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (i_ctrl_awvalid && i_ctrl_awready) aw_done <= 1'b1;
      if (i_ctrl_wvalid && i_ctrl_wready)   w_done  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            ar_done <= 1'b0;
    else if (rrel)                           ar_done <= 1'b0;
    else if (i_ctrl_arvalid && i_ctrl_arready) ar_done <= 1'b1;
  end

  pio_arb2 u_warb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({t1_ctrl_awvalid, t0_ctrl_awvalid}),
    .rel     (wrel),
    .grant   (wgrant),
    .state   (wr_state)
  );

  pio_arb2 u_rarb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({t1_ctrl_arvalid, t0_ctrl_arvalid}),
    .rel     (rrel),
    .grant   (rgrant),
    .state   (rd_state)
  );

endmodule

// File: tb/tb_pio_axil_arbiter.sv
// Bench for pio_axil_arbiter: two manager drivers, a small PIO register model as the shared subordinate.
module tb_pio_axil_arbiter;
  import pio_arb_pkg::*;

  logic clk;
  logic reset_n;

  logic        t_awvalid[2], t_wvalid[2], t_bready[2], t_arvalid[2], t_rready[2];
  logic [31:0] t_awaddr[2], t_wdata[2], t_araddr[2];
  logic [2:0]  t_awprot[2], t_arprot[2];
  logic [3:0]  t_wstrb[2];
  logic        t_awready[2], t_wready[2], t_bvalid[2], t_arready[2], t_rvalid[2];
  logic [1:0]  t_bresp[2], t_rresp[2];
  logic [31:0] t_rdata[2];

  logic        i_awvalid, i_awready, i_wvalid, i_wready, i_bvalid, i_bready;
  logic        i_arvalid, i_arready, i_rvalid, i_rready;
  logic [31:0] i_awaddr, i_wdata, i_araddr, i_rdata;
  logic [2:0]  i_awprot, i_arprot;
  logic [3:0]  i_wstrb;
  logic [1:0]  i_bresp, i_rresp;
  logic [1:0]  wgrant, rgrant;
  arb_state_t  wr_state, rd_state;

  int checks = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pio_axil_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .t0_ctrl_awvalid(t_awvalid[0]), .t0_ctrl_awaddr(t_awaddr[0]), .t0_ctrl_awprot(t_awprot[0]),
    .t0_ctrl_awready(t_awready[0]), .t0_ctrl_wvalid(t_wvalid[0]), .t0_ctrl_wdata(t_wdata[0]),
    .t0_ctrl_wstrb(t_wstrb[0]), .t0_ctrl_wready(t_wready[0]), .t0_ctrl_bvalid(t_bvalid[0]),
    .t0_ctrl_bresp(t_bresp[0]), .t0_ctrl_bready(t_bready[0]), .t0_ctrl_arvalid(t_arvalid[0]),
    .t0_ctrl_araddr(t_araddr[0]), .t0_ctrl_arprot(t_arprot[0]), .t0_ctrl_arready(t_arready[0]),
    .t0_ctrl_rvalid(t_rvalid[0]), .t0_ctrl_rdata(t_rdata[0]), .t0_ctrl_rresp(t_rresp[0]),
    .t0_ctrl_rready(t_rready[0]),
    .t1_ctrl_awvalid(t_awvalid[1]), .t1_ctrl_awaddr(t_awaddr[1]), .t1_ctrl_awprot(t_awprot[1]),
    .t1_ctrl_awready(t_awready[1]), .t1_ctrl_wvalid(t_wvalid[1]), .t1_ctrl_wdata(t_wdata[1]),
    .t1_ctrl_wstrb(t_wstrb[1]), .t1_ctrl_wready(t_wready[1]), .t1_ctrl_bvalid(t_bvalid[1]),
    .t1_ctrl_bresp(t_bresp[1]), .t1_ctrl_bready(t_bready[1]), .t1_ctrl_arvalid(t_arvalid[1]),
    .t1_ctrl_araddr(t_araddr[1]), .t1_ctrl_arprot(t_arprot[1]), .t1_ctrl_arready(t_arready[1]),
    .t1_ctrl_rvalid(t_rvalid[1]), .t1_ctrl_rdata(t_rdata[1]), .t1_ctrl_rresp(t_rresp[1]),
    .t1_ctrl_rready(t_rready[1]),
    .i_ctrl_awvalid(i_awvalid), .i_ctrl_awaddr(i_awaddr), .i_ctrl_awprot(i_awprot),
    .i_ctrl_awready(i_awready), .i_ctrl_wvalid(i_wvalid), .i_ctrl_wdata(i_wdata),
    .i_ctrl_wstrb(i_wstrb), .i_ctrl_wready(i_wready), .i_ctrl_bvalid(i_bvalid),
    .i_ctrl_bresp(i_bresp), .i_ctrl_bready(i_bready), .i_ctrl_arvalid(i_arvalid),
    .i_ctrl_araddr(i_araddr), .i_ctrl_arprot(i_arprot), .i_ctrl_arready(i_arready),
    .i_ctrl_rvalid(i_rvalid), .i_ctrl_rdata(i_rdata), .i_ctrl_rresp(i_rresp),
    .i_ctrl_rready(i_rready),
    .wgrant(wgrant), .rgrant(rgrant), .wr_state(wr_state), .rd_state(rd_state)
  );

  // PIO model: 0x0 odata, 0x4 oenable, 0x8 idata (read-only); answers one cycle after address+data.
  logic [31:0] pio_reg[2];
  logic [31:0] idata;
  logic        b_hold;
  logic        s_aw_got, s_w_got;
  logic [31:0] s_addr_q, s_data_q;
  logic        s_aw_now, s_w_now;
  logic [31:0] s_waddr, s_wdat;

  assign i_awready = !s_aw_got && !i_bvalid;
  assign i_wready  = !s_w_got && !i_bvalid;
  assign i_arready = !i_rvalid;
  assign i_bresp   = 2'b00;
  assign i_rresp   = 2'b00;
  assign s_aw_now  = s_aw_got || (i_awvalid && i_awready);
  assign s_w_now   = s_w_got || (i_wvalid && i_wready);
  assign s_waddr   = s_aw_got ? s_addr_q : i_awaddr;
  assign s_wdat    = s_w_got ? s_data_q : i_wdata;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_aw_got <= 1'b0; s_w_got <= 1'b0; i_bvalid <= 1'b0; i_rvalid <= 1'b0;
      s_addr_q <= '0; s_data_q <= '0; i_rdata <= '0;
      pio_reg[0] <= '0; pio_reg[1] <= '0;
    end else begin
      if (i_bvalid) begin
        if (i_bready) i_bvalid <= 1'b0;
      end else if (s_aw_now && s_w_now && !b_hold) begin
        i_bvalid <= 1'b1; s_aw_got <= 1'b0; s_w_got <= 1'b0;
        if (s_waddr[3:2] == 2'd0) pio_reg[0] <= s_wdat;
        if (s_waddr[3:2] == 2'd1) pio_reg[1] <= s_wdat;
      end else begin
        if (i_awvalid && i_awready) begin s_aw_got <= 1'b1; s_addr_q <= i_awaddr; end
        if (i_wvalid && i_wready)   begin s_w_got <= 1'b1;  s_data_q <= i_wdata;  end
      end
      if (i_rvalid) begin
        if (i_rready) i_rvalid <= 1'b0;
      end else if (i_arvalid && i_arready) begin
        i_rvalid <= 1'b1;
        case (i_araddr[3:2])
          2'd0:    i_rdata <= pio_reg[0];
          2'd1:    i_rdata <= pio_reg[1];
          2'd2:    i_rdata <= idata;
          default: i_rdata <= '0;
        endcase
      end
    end
  end

  // Monitors: observed B owners, forwarded W beats and rule violations.
  int  b_owner_q[$];
  int  w_beats = 0, early_w = 0, t1_viol = 0, t0_b_viol = 0;
  bit  saw_split = 0;
  logic [1:0] aw_owner = 2'b00;
  bit  mon_t1_quiet = 0, mon_t0_nob = 0;

  always @(negedge clk) begin
    if (i_bvalid && i_bready) b_owner_q.push_back((wgrant == 2'b10) ? 1 : 0);
    if (i_wvalid && i_wready) w_beats <= w_beats + 1;
    if (i_wvalid && wgrant == 2'b00) early_w <= early_w + 1;
    if (mon_t1_quiet && (t_awready[1] || t_wready[1] || t_bvalid[1] || t_arready[1] || t_rvalid[1]))
      t1_viol <= t1_viol + 1;
    if (mon_t0_nob && t_bvalid[0]) t0_b_viol <= t0_b_viol + 1;
    if (wgrant == 2'b01 && rgrant == 2'b10) saw_split <= 1'b1;
    if (i_awvalid) aw_owner <= wgrant;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mgr_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                           input int w_lead, output logic [1:0] resp, output int lat, output bit ok);
    int n; int aw_start; bit aw_hs, w_hs, b_hs;
    n = 0; aw_start = -1; ok = 0; resp = 2'b11; lat = -1;
    @(negedge clk);
    t_awaddr[m] = addr; t_awprot[m] = 3'd0; t_wdata[m] = data; t_wstrb[m] = 4'hF;
    t_wvalid[m] = 1'b1; t_bready[m] = 1'b1;
    while (!ok && n < 60) begin
      if (aw_start < 0 && n >= w_lead) begin t_awvalid[m] = 1'b1; aw_start = n; end
      #1;
      aw_hs = t_awvalid[m] && t_awready[m];
      w_hs  = t_wvalid[m] && t_wready[m];
      b_hs  = t_bvalid[m] && t_bready[m];
      if (b_hs) resp = t_bresp[m];
      @(negedge clk); n++;
      if (aw_hs) t_awvalid[m] = 1'b0;
      if (w_hs)  t_wvalid[m] = 1'b0;
      if (b_hs) begin ok = 1; lat = n - aw_start; end
    end
    t_awvalid[m] = 1'b0; t_wvalid[m] = 1'b0; t_bready[m] = 1'b0;
  endtask

  task automatic mgr_read(input int m, input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat, output bit ok);
    int n; bit ar_hs, r_hs;
    n = 0; ok = 0; resp = 2'b11; lat = -1; data = '0;
    @(negedge clk);
    t_araddr[m] = addr; t_arprot[m] = 3'd0; t_arvalid[m] = 1'b1; t_rready[m] = 1'b1;
    while (!ok && n < 60) begin
      #1;
      ar_hs = t_arvalid[m] && t_arready[m];
      r_hs  = t_rvalid[m] && t_rready[m];
      if (r_hs) begin data = t_rdata[m]; resp = t_rresp[m]; end
      @(negedge clk); n++;
      if (ar_hs) t_arvalid[m] = 1'b0;
      if (r_hs) begin ok = 1; lat = n; end
    end
    t_arvalid[m] = 1'b0; t_rready[m] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference model state: register contents and last write owner for tie-breaking.
  logic [31:0] exp_reg[2];
  int          last_w;
  logic [31:0] exp_q[$];

  initial begin
    logic [1:0]  resp, resp1;
    logic [31:0] rdata;
    int          lat, lat1, first, second, wb0, ew0, tb0;
    bit          ok, ok1;
    logic [31:0] tie_data[2];

    for (int i = 0; i < 2; i++) begin
      t_awvalid[i] = 0; t_wvalid[i] = 0; t_bready[i] = 0; t_arvalid[i] = 0; t_rready[i] = 0;
      t_awaddr[i] = 0; t_wdata[i] = 0; t_araddr[i] = 0; t_awprot[i] = 0; t_arprot[i] = 0;
      t_wstrb[i] = 0;
    end
    idata = 32'h2A5; b_hold = 1'b0;
    exp_reg[0] = 0; exp_reg[1] = 0; last_w = 0;
    tie_data[0] = 32'h0AA; tie_data[1] = 32'h155;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {wgrant, rgrant, i_awvalid, i_wvalid, i_arvalid, i_bready, i_rready,
        t_awready[0], t_awready[1], t_wready[0], t_wready[1], t_bvalid[0], t_bvalid[1],
        t_arready[0], t_arready[1], t_rvalid[0], t_rvalid[1]}, 64'd0);
    chk("reset_state", {wr_state, rd_state}, {IDLE, IDLE});
    @(negedge clk); reset_n = 1'b1;

    // t0 write 0x3FF to oenable, then read it back; t1 must stay silent.
    mon_t1_quiet = 1;
    mgr_write(0, 32'h4, 32'h3FF, 0, resp, lat, ok);
    exp_reg[1] = 32'h3FF; last_w = 0;
    chk("t0_write_done", ok, 1);
    chk("t0_write_bresp", resp, 2'b00);
    chk("t0_write_latency", lat, 3);
    chk("t0_write_grant", aw_owner, 2'b01);
    chk("pio_oenable", pio_reg[1], exp_reg[1]);
    mgr_read(0, 32'h4, rdata, resp, lat, ok);
    chk("t0_read_done", ok, 1);
    chk("t0_read_rdata", rdata, exp_reg[1]);
    chk("t0_read_rresp", resp, 2'b00);
    chk("t0_read_latency", lat, 3);
    mon_t1_quiet = 0;
    chk("t1_quiet", t1_viol, 0);

    // Simultaneous writes to odata, repeated to exercise the tie-break history.
    for (int rep = 0; rep < 2; rep++) begin
`ifdef PIO_ARB_RR_EN
      first = (last_w == 0) ? 1 : 0;
`else
      first = 0;
`endif
      second = 1 - first;
      b_owner_q.delete();
      fork
        mgr_write(0, 32'h0, tie_data[0], 0, resp, lat, ok);
        mgr_write(1, 32'h0, tie_data[1], 0, resp1, lat1, ok1);
      join
      exp_reg[0] = tie_data[second]; last_w = second;
      chk("tie_both_done", {ok, ok1}, 2'b11);
      chk("tie_owner_count", b_owner_q.size(), 2);
      if (b_owner_q.size() == 2) begin
        chk("tie_first_owner", b_owner_q[0], first);
        chk("tie_second_owner", b_owner_q[1], second);
      end
      chk("tie_odata", pio_reg[0], exp_reg[0]);
    end

    // t0 write held open while t1 reads idata: both grants live at once.
    b_hold = 1'b1;
    fork
      mgr_write(0, 32'h4, 32'h1C3, 0, resp, lat, ok);
      begin
        @(negedge clk);
        mgr_read(1, 32'h8, rdata, resp1, lat1, ok1);
        b_hold = 1'b0;
      end
    join
    exp_reg[1] = 32'h1C3; last_w = 0;
    chk("split_grants_seen", saw_split, 1);
    chk("split_t1_rdata", rdata, idata);
    chk("split_t1_rresp", resp1, 2'b00);
    chk("split_t0_write_done", ok, 1);
    chk("split_oenable", pio_reg[1], exp_reg[1]);

    // t1 presents W three cycles ahead of AW.
    wb0 = w_beats; ew0 = early_w; tb0 = t0_b_viol;
    mon_t0_nob = 1;
    mgr_write(1, 32'h0, 32'h2D2, 3, resp, lat, ok);
    mon_t0_nob = 0;
    exp_reg[0] = 32'h2D2; last_w = 1;
    chk("wlead_done", ok, 1);
    chk("wlead_latency", lat, 3);
    chk("wlead_w_beats", w_beats - wb0, 1);
    chk("wlead_no_early_w", early_w - ew0, 0);
    chk("wlead_no_t0_b", t0_b_viol - tb0, 0);
    chk("wlead_odata", pio_reg[0], exp_reg[0]);

    // Reset pulse while the write path is busy and B is being held back.
    b_hold = 1'b1;
    @(negedge clk);
    t_awaddr[0] = 32'h0; t_wdata[0] = 32'h123; t_wstrb[0] = 4'hF;
    t_awvalid[0] = 1'b1; t_wvalid[0] = 1'b1; t_bready[0] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("midreset_busy_grant", wgrant, 2'b01);
    @(negedge clk); reset_n = 1'b0;
    #1;
    chk("midreset_outputs", {wgrant, rgrant, i_awvalid, i_wvalid, i_arvalid, i_bready, i_rready,
        t_awready[0], t_wready[0], t_bvalid[0], t_bvalid[1]}, 64'd0);
    chk("midreset_state", wr_state, IDLE);
    t_awvalid[0] = 1'b0; t_wvalid[0] = 1'b0; t_bready[0] = 1'b0;
    b_hold = 1'b0;
    exp_reg[0] = 0; exp_reg[1] = 0; last_w = 0;
    @(negedge clk); reset_n = 1'b1;
    mgr_write(1, 32'h4, 32'h0F0, 0, resp, lat, ok);
    exp_reg[1] = 32'h0F0; last_w = 1;
    chk("postreset_done", ok, 1);
    chk("postreset_latency", lat, 3);
    chk("postreset_oenable", pio_reg[1], exp_reg[1]);
    chk("postreset_odata", pio_reg[0], exp_reg[0]);

    // Random write/read-back traffic from either manager.
    for (int it = 0; it < 8; it++) begin
      int wm, rm, wa, ra, lead;
      logic [31:0] d;
      wm = $urandom_range(0, 1); rm = $urandom_range(0, 1);
      wa = $urandom_range(0, 2); ra = $urandom_range(0, 2);
      lead = $urandom_range(0, 2); d = $urandom;
      mgr_write(wm, 32'(wa * 4), d, lead, resp, lat, ok);
      if (wa < 2) exp_reg[wa] = d;
      last_w = wm;
      chk("rand_write_done", ok, 1);
      chk("rand_write_bresp", resp, 2'b00);
      exp_q.push_back((ra == 2) ? idata : exp_reg[ra]);
      mgr_read(rm, 32'(ra * 4), rdata, resp, lat, ok);
      chk("rand_read_done", ok, 1);
      chk("rand_read_rdata", rdata, exp_q.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pio_axil_arbiter.md
# pio_axil_arbiter

Two-manager AXI4-Lite arbiter that shares the single `t_ctrl` control port of the PIO block between two independent requesters, e.g. a host CPU and a DMA/sequencer. Write and read paths are arbitrated independently, and each path carries one transaction at a time. Each grant is held from the address handshake until the response handshake, so the PIO's W_I/W_A/W_D and R_I/R_D FSMs never see interleaved traffic.

## Interface
Parameters:
- addrWidth, 32, address width on all ports
- dataWidth, 32, data width on all ports
- writeStrobeWidth, 4, dataWidth/8

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- t{0,1}_ctrl_awvalid/awaddr/awprot  in  1/addrWidth/3  manager n write address; t{0,1}_ctrl_awready out 1
- t{0,1}_ctrl_wvalid/wdata/wstrb  in  1/dataWidth/writeStrobeWidth  manager n write data; t{0,1}_ctrl_wready out 1
- t{0,1}_ctrl_bvalid/bresp  out  1/2  manager n write response; t{0,1}_ctrl_bready in 1
- t{0,1}_ctrl_arvalid/araddr/arprot  in  1/addrWidth/3  manager n read address; t{0,1}_ctrl_arready out 1
- t{0,1}_ctrl_rvalid/rdata/rresp  out  1/dataWidth/2  manager n read data; t{0,1}_ctrl_rready in 1
- i_ctrl_aw*/w*/ar* valid+payload  out; matching readys  in  shared initiator port to the PIO
- i_ctrl_bvalid/bresp/rvalid/rdata/rresp  in; i_ctrl_bready/rready  out
- wgrant  out  2  one-hot write owner (00 = idle)
- rgrant  out  2  one-hot read owner

## Operation
- Write FSM: WA_IDLE → WA_BUSY → WA_IDLE.
  - WA_IDLE: all t*_awready/wready = 0 and i_ctrl_awvalid/wvalid = 0.
  - Any t{n}_ctrl_awvalid = 1 → register the grant and move to WA_BUSY. wvalid alone does not request.
  - WA_BUSY: the granted manager's AW, W and B channels are combinationally connected to i_ctrl. The other manager sees ready = 0 and bvalid = 0.
  - Flags aw_done/w_done latch the i_ctrl AW and W handshakes. After a channel's flag is set, its i_ctrl valid is forced 0, so no duplicate beat reaches the PIO.
  - Exit on the i_ctrl_bvalid & i_ctrl_bready handshake, after both flags are set. Exit clears the grant and both flags.
- Read FSM: RA_IDLE → RA_BUSY → RA_IDLE, with the same rules on AR/R. Exit on the i_ctrl_rvalid & rready handshake.
- The write and read FSMs are fully independent. One manager may own the write path while the other owns the read path.
- Arbitration is 2-way. Ties are resolved per the Configuration section.
- Payloads (addr, prot, data, strb, resp) pass through unmodified. bresp/rresp toward a non-granted manager = 2'b00.

## Timing
- Reset values: all valid and ready outputs 0; wgrant = rgrant = 00; FSMs in IDLE; round-robin pointers = 0.
- The grant is registered:
  - First i_ctrl_awvalid/arvalid asserts 1 cycle after the request appears.
  - The PIO then takes 1 cycle to respond, so minimum write = 3 cycles from awvalid to B handshake; minimum read = 3 cycles from arvalid to R handshake.
- In BUSY there is zero added latency on valid, ready and payload (combinational path).
- Back-to-back: a new request can be granted in the cycle after the response handshake, so there is 1 idle cycle between transactions.
- A request withdrawn before the grant is not AXI-legal and is not checked. The grant is still taken.
- Reset asserted mid-transaction: immediate return to IDLE and all outputs to reset values. An in-flight PIO beat is abandoned.

## Configuration
- PIO_ARB_RR_EN defined: round-robin.
  - Each path keeps a last-owner pointer, updated at transaction exit.
  - On a simultaneous request, the manager that is not the last owner wins.
- PIO_ARB_RR_EN undefined: fixed priority. Manager 0 always wins ties, and no pointer flops are built.

## Structure
- Package pio_arb_pkg holds:
  - the arb_state_t enum {IDLE, BUSY}
  - the GRANT_NONE/GRANT_0/GRANT_1 localparams
- Sub-module pio_arb2 holds one 2-way arbiter: request pair, pointer and registered one-hot grant, with a release input.
  - Instantiated twice, once for write and once for read.
  - Contains the PIO_ARB_RR_EN conditional.

## Test plan
- t0 writes 0x3FF to addr 0x4, then t0 reads addr 0x4.
  - Expect wgrant = 01 for the write, the PIO oenable = 0x3FF, and t0_ctrl_rdata = 0x3FF with rresp = 00.
  - t1 sees no ready and no valid throughout.
- t0 and t1 assert awvalid in the same cycle (t0 data 0x0AA, t1 data 0x155, addr 0x0).
  - Fixed priority: t0 is served first, then t1, and odata ends at 0x155.
  - RR build: the order alternates on a repeat of the same stimulus.
- t0 holds a write while t1 issues a read of addr 0x8 with idata = 0x2A5.
  - Expect wgrant = 01 and rgrant = 10 concurrently, and t1 rdata = 0x2A5.
- t1 presents W 3 cycles before AW.
  - Expect no i_ctrl_wvalid before the grant and exactly one W beat forwarded.
  - B is returned only to t1.
- reset_n pulses low in WA_BUSY before B.
  - Expect wgrant = 00, all valids 0, and a following t1 write completing normally.
